ram_read_sequencer: RTL
=======================

# ram_read_sequencer

Read-side burst engine that sits directly downstream of the dual-port RAM in the `read_clk` domain. A single start command sweeps a contiguous, wrap-around address range. The engine drives the RAM read address and tracks the RAM's fixed 2-cycle read latency. Returned words are delivered on a valid/ready output stream with full backpressure, buffered in a 4-entry skid FIFO, with no loss or duplication.

## Interface
Parameters:
- DW, 8, data width; must match the RAM word width.
- AW, 6, address width; RAM depth is 2^AW = 64.
- BUF_DEPTH, 4, output buffer depth; also the outstanding-read limit.

Ports:
- read_clk  input  1  sole clock; all logic is on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  burst request; sampled only in IDLE.
- start_addr  input  AW  first address of the burst.
- length  input  AW+1  word count 0..64; values 65..127 are clamped to 64.
- busy  output  1  high in RUN or DRAIN.
- done  output  1  one-cycle pulse at burst completion.
- read_addr  output  AW  registered address to the RAM read port.
- q  input  DW  RAM read data.
- out_data  output  DW  head word of the output buffer.
- out_valid  output  1  output buffer is not empty.
- out_ready  input  1  consumer accepts the word; a transfer occurs when out_valid && out_ready.

## Operation
- FSM states and transitions:
  - IDLE -> RUN on start with length != 0. The engine latches start_addr and length and clears the issue and pop counters.
  - start with length == 0 produces a done pulse on the next cycle and no data. The FSM stays in IDLE.
  - RUN -> DRAIN when the last address has been issued.
  - DRAIN -> IDLE on the edge where the final word transfers. done = 1 and busy = 0 during the following cycle.
  - RUN -> IDLE directly if the final issue and final pop can coincide. The same done rule applies.
- Issue rule: a read issues in a cycle when state == RUN, words remain, and (s1 + s2 + buf_count) < BUF_DEPTH.
  - On an issue edge, read_addr advances by 1, modulo 2^AW. Address 63 wraps to 0.
  - With no issue, read_addr holds its value.
- Latency tracking: a 2-stage valid shift register mirrors the RAM.
  - s1 = address captured by the RAM's registered read address.
  - s2 = q now holds that word.
  - When s2 is set, q is written into the buffer on the next edge.
- The buffer is a FIFO. out_data is the head and stays stable while out_valid && !out_ready.
- The credit rule guarantees the buffer never overflows. Overflow is an assertion failure in the bench.
- start is ignored while busy. length and start_addr are not re-sampled during a burst.
- Burst words are delivered in strictly ascending address order, with wrap. Word count equals the clamped length.

## Timing
- Reset values: read_addr = 0, out_valid = 0, out_data = 0, busy = 0, done = 0. State = IDLE, buffer empty, s1 = s2 = 0.
- Reset mid-burst: the burst is aborted immediately. In-flight RAM data is discarded. No done pulse follows.
- start sampled at edge E0 gives these events:
  - read_addr = start_addr during cycle E0..E1. The first issue is at E1.
  - The RAM registers the address at E1. q is valid after E2. The word enters the buffer at E3.
  - out_valid rises after E3. First-word latency is 3 cycles from the start edge.
- With out_ready held high, throughput is 1 word per cycle. Steady state is s1 = s2 = 1 and buf_count = 1.
- With out_ready low, at most 4 reads are outstanding. read_addr freezes until a pop frees a credit.
- busy rises in the cycle after E0. busy falls in the same cycle that done is high.
- A simultaneous push and pop on a full buffer is legal; the count is unchanged.
- A simultaneous push and pop on an empty buffer is not possible, because the push is registered first.

## Test plan
- Reset: assert rst mid-cycle -> all outputs 0 immediately. Hold 3 cycles and release -> FSM in IDLE and out_valid = 0.
- Basic burst: preload ram[i] = i ^ 8'hA5. start_addr = 5, length = 4, out_ready = 1, start at E0 -> out_data = 0xA0, 0xA3, 0xA2, 0xAD valid after E3..E6. done = 1 for exactly one cycle after E7. busy = 0 from then.
- Wrap-around: start_addr = 62, length = 4 -> read_addr sequence 62, 63, 0, 1. Output is ram[62], ram[63], ram[0], ram[1].
- Backpressure: length = 8, out_ready = 0 for 12 cycles after start -> exactly 4 issues, then read_addr frozen. out_valid = 1 with out_data = ram[start_addr] held stable. Release ready -> remaining 7 words in order, then one done pulse.
- Corner commands: length = 0 -> done pulse next cycle, out_valid never high. length = 100 -> exactly 64 words with the address wrapping once. start pulsed while busy -> ignored, word count unchanged.
- Reset mid-burst: assert rst after 2 words have transferred of length = 10 -> out_valid = 0 and busy = 0 immediately, no done pulse. A new burst started afterwards delivers the correct data from its own start_addr.

Source files
------------

// File: rtl/ram_read_sequencer.sv
// Read-side burst engine: sweeps a wrap-around address range on the RAM read port,
// tracks the 2-cycle RAM latency and delivers words through a credit-limited skid FIFO.
module ram_read_sequencer #(
  parameter int DW        = 8,
  parameter int AW        = 6,
  parameter int BUF_DEPTH = 4
) (
  input  logic          read_clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] start_addr,
  input  logic [AW:0]   length,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] read_addr,
  input  logic [DW-1:0] q,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready
);

  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam logic [AW:0] MAX_LEN = {1'b1, {AW{1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t        state;
  logic [AW:0]   len;
  logic [AW:0]   issued;
  logic [AW:0]   popped;
  logic          s1;
  logic          s2;
  logic [DW-1:0] mem [BUF_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] buf_count;

  logic [AW:0]   len_clamped;
  logic [CW:0]   inflight;
  logic          issue;
  logic          push;
  logic          pop;
  logic          last_issue;
  logic          last_pop;

  always_comb begin
    len_clamped = (length > MAX_LEN) ? MAX_LEN : length;
    // Reads already launched plus words buffered must fit in the FIFO.
    inflight    = (CW+1)'(s1) + (CW+1)'(s2) + (CW+1)'(buf_count);
    issue       = (state == RUN) && (issued != len) && (inflight < (CW+1)'(BUF_DEPTH));
    push        = s2;
    out_valid   = (buf_count != '0);
    pop         = out_valid && out_ready;
    out_data    = mem[rd_ptr];
    last_issue  = issue && (issued == len - 1'b1);
    last_pop    = pop && (state != IDLE) && (popped == len - 1'b1);
  end

  always_ff @(posedge read_clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      len       <= '0;
      issued    <= '0;
      popped    <= '0;
      s1        <= 1'b0;
      s2        <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      buf_count <= '0;
      read_addr <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      for (int unsigned i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
    end else begin
      done <= 1'b0;
      s1   <= issue;
      s2   <= s1;

      if (push) begin
        mem[wr_ptr] <= q;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        popped <= popped + 1'b1;
      end
      if (push && !pop)      buf_count <= buf_count + 1'b1;
      else if (pop && !push) buf_count <= buf_count - 1'b1;

      if (issue) begin
        read_addr <= read_addr + 1'b1;
        issued    <= issued + 1'b1;
      end

      case (state)
        IDLE: begin
          if (start) begin
            if (len_clamped == '0) begin
              done <= 1'b1;
            end else begin
              state     <= RUN;
              busy      <= 1'b1;
              read_addr <= start_addr;
              len       <= len_clamped;
              issued    <= '0;
              popped    <= '0;
            end
          end
        end
        RUN: begin
          if (last_pop) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (last_issue) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (last_pop) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
